dpram_xfer_responder: RTL and testbench

DPRAM_XFER_RESPONDER -- requirements
Module: dpram_xfer_responder

---
 rtl/dpram_xfer_responder.sv | 149 ++++++++++++++
 tb/tb_dpram_xfer_responder.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_xfer_responder.sv
// dpram_xfer_responder: drains a filled DPRAM buffer as a valid/ready
// word stream. The DPRAM read has one cycle of registered latency.
module dpram_xfer_responder #(
   parameter int P_DPRAM_ADR_WIDTH = 10,
   parameter int P_CNT_WIDTH       = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         cfg_mode,
   input  logic                         dpram_run,
   input  logic [15:0]                  dpram_len,
   output logic                         dpram_busy,
   output logic                         dpram_mode,
   output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
   input  logic [31:0]                  dpram_rd_data,
   output logic [31:0]                  out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic [P_CNT_WIDTH-1:0]       xfer_count,
   output logic                         err_len
);

   localparam int     AW    = P_DPRAM_ADR_WIDTH;
   localparam longint DEPTH = longint'(1) << AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CAPT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t                 state, state_d;
   logic                   busy_d;
   logic                   mode_d;
   logic [AW-1:0]          addr_d;
   logic [31:0]            data_d;
   logic                   valid_d;
   logic [P_CNT_WIDTH-1:0] cnt_d;
   logic                   err_d;
   logic [AW-1:0]          last_addr, last_addr_d;
   logic                   bad, bad_d;
   logic                   len_ok;

   assign len_ok = (dpram_len != 16'd0) &&
                   (longint'(dpram_len) <= DEPTH);

   assign out_last = out_valid && (dpram_rd_addr == last_addr);

   always_comb begin
      state_d     = state;
      busy_d      = dpram_busy;
      mode_d      = dpram_mode;
      addr_d      = dpram_rd_addr;
      data_d      = out_data;
      valid_d     = out_valid;
      cnt_d       = xfer_count;
      err_d       = err_len;
      last_addr_d = last_addr;
      bad_d       = bad;
      if (!en) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         valid_d = 1'b0;
         if (state == S_IDLE) begin
            mode_d = cfg_mode;
         end
      end else begin
         unique case (state)
            S_IDLE: begin
               mode_d = cfg_mode;
               if (dpram_run) begin
                  busy_d = 1'b1;
                  addr_d = '0;
                  if (len_ok) begin
                     last_addr_d = AW'(dpram_len - 16'd1);
                     bad_d       = 1'b0;
                     state_d     = S_ADDR;
                  end else begin
                     // S_DONE drops busy after one cycle, no count
                     err_d   = 1'b1;
                     bad_d   = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_ADDR: begin
               state_d = S_CAPT;
            end
            S_CAPT: begin
               data_d  = dpram_rd_data;
               valid_d = 1'b1;
               state_d = S_PRESENT;
            end
            S_PRESENT: begin
               if (out_ready) begin
                  valid_d = 1'b0;
                  if (dpram_rd_addr == last_addr) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = dpram_rd_addr + 1'b1;
                     state_d = S_ADDR;
                  end
               end
            end
            S_DONE: begin
               busy_d = 1'b0;
               if (!bad) begin
                  cnt_d = xfer_count + 1'b1;
               end
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         dpram_busy    <= 1'b0;
         dpram_mode    <= 1'b0;
         dpram_rd_addr <= '0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         xfer_count    <= '0;
         err_len       <= 1'b0;
         last_addr     <= '0;
         bad           <= 1'b0;
      end else begin
         state         <= state_d;
         dpram_busy    <= busy_d;
         dpram_mode    <= mode_d;
         dpram_rd_addr <= addr_d;
         out_data      <= data_d;
         out_valid     <= valid_d;
         xfer_count    <= cnt_d;
         err_len       <= err_d;
         last_addr     <= last_addr_d;
         bad           <= bad_d;
      end
   end

endmodule

// File: tb/tb_dpram_xfer_responder.sv
// tb_dpram_xfer_responder: randomized bench with a transaction-level
// model of the buffer drain (words, last flag, busy length, counters).
module tb_dpram_xfer_responder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          cfg_mode = 1'b0;
   logic          dpram_run = 1'b0;
   logic [15:0]   dpram_len = '0;
   logic          out_ready = 1'b1;
   logic          dpram_busy, dpram_mode, out_valid, out_last, err_len;
   logic [AW-1:0] dpram_rd_addr;
   logic [31:0]   dpram_rd_data, out_data, xfer_count;

   logic          b_busy, b_mode, b_valid, b_last, b_err;
   logic [AW-1:0] b_addr;
   logic [31:0]   b_data;
   logic [1:0]    b_count;

   logic [31:0]   mem [0:1023];

   int            n_checks = 0;
   int            n_pass = 0;
   int            exp_cnt = 0;
   bit            exp_err = 1'b0;

   logic [31:0]   obs_words[$];
   bit            obs_last[$];
   int            r_busy, r_stall, r_unstable, r_lat, r_mode_chg;
   bit            r_tmo, r_vseen;

   always #5 clk = ~clk;

   always @(posedge clk) dpram_rd_data <= mem[dpram_rd_addr];

   dpram_xfer_responder #(
      .P_DPRAM_ADR_WIDTH(AW),
      .P_CNT_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_mode(cfg_mode),
      .dpram_run(dpram_run), .dpram_len(dpram_len),
      .dpram_busy(dpram_busy), .dpram_mode(dpram_mode),
      .dpram_rd_addr(dpram_rd_addr), .dpram_rd_data(dpram_rd_data),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last),
      .xfer_count(xfer_count), .err_len(err_len)
   );

   dpram_xfer_responder #(
      .P_DPRAM_ADR_WIDTH(AW),
      .P_CNT_WIDTH(2)
   ) dut2 (
      .clk(clk), .rst(rst), .en(en), .cfg_mode(cfg_mode),
      .dpram_run(dpram_run), .dpram_len(dpram_len),
      .dpram_busy(b_busy), .dpram_mode(b_mode),
      .dpram_rd_addr(b_addr), .dpram_rd_data(dpram_rd_data),
      .out_data(b_data), .out_valid(b_valid),
      .out_ready(out_ready), .out_last(b_last),
      .xfer_count(b_count), .err_len(b_err)
   );

   // Pulses one run and follows it until busy drops, recording what
   // the stream delivered; comparisons are left to the callers.
   task automatic drive_run(input int len, input int stall_first,
                            input int stall_pct, input int ghost_at,
                            input bit mode);
      int cyc;
      int stalled;
      bit pv;
      logic [31:0] pd;
      obs_words.delete();
      obs_last.delete();
      r_busy = 0; r_stall = 0; r_unstable = 0; r_lat = -1;
      r_mode_chg = 0; r_tmo = 0; r_vseen = 0;
      @(negedge clk);
      cfg_mode = mode;
      dpram_run = 1'b1;
      dpram_len = 16'(len);
      out_ready = 1'b1;
      @(negedge clk);
      dpram_run = 1'b0;
      cyc = 0; stalled = 0; pv = 0; pd = '0;
      while (dpram_busy === 1'b1) begin
         if (cyc >= 5000) begin
            r_tmo = 1;
            break;
         end
         r_busy++;
         if (dpram_mode !== mode) r_mode_chg++;
         cfg_mode = 1'($urandom);
         dpram_run = (cyc == ghost_at);
         dpram_len = 16'($urandom_range(1, 8));
         if (pv && (out_valid !== 1'b1 || out_data !== pd))
            r_unstable++;
         if (out_valid === 1'b1) begin
            r_vseen = 1;
            if (r_lat < 0) r_lat = cyc;
            if (stalled < stall_first) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (out_ready) begin
               obs_words.push_back(out_data);
               obs_last.push_back(out_last === 1'b1);
            end else begin
               stalled++;
               r_stall++;
            end
         end else begin
            out_ready = 1'($urandom);
         end
         pv = (out_valid === 1'b1) && !out_ready;
         pd = out_data;
         @(negedge clk);
         cyc++;
      end
      dpram_run = 1'b0;
      out_ready = 1'b1;
      cfg_mode = mode;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dpram_busy !== 1'b0)
         $display("FAIL reset_busy: got %b want 0", dpram_busy);
      else n_pass++;
      n_checks++;
      if (dpram_mode !== 1'b0)
         $display("FAIL reset_mode: got %b want 0", dpram_mode);
      else n_pass++;
      n_checks++;
      if (dpram_rd_addr !== '0)
         $display("FAIL reset_addr: got %h want 0", dpram_rd_addr);
      else n_pass++;
      n_checks++;
      if (out_data !== 32'h0 || out_valid !== 1'b0 || out_last !== 1'b0)
         $display("FAIL reset_out: got %h/%b/%b want 0/0/0",
                  out_data, out_valid, out_last);
      else n_pass++;
      n_checks++;
      if (xfer_count !== 32'h0 || b_count !== 2'd0 || err_len !== 1'b0)
         $display("FAIL reset_cnt: got %0d/%0d/%b want 0/0/0",
                  xfer_count, b_count, err_len);
      else n_pass++;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
      drive_run(4, 0, 0, -1, 1'b0);
      exp_cnt++;
      n_checks++;
      if (r_tmo || obs_words.size() != 4)
         $display("FAIL basic_nwords: got %0d tmo %b want 4",
                  obs_words.size(), r_tmo);
      else n_pass++;
      for (int i = 0; i < 4 && i < obs_words.size(); i++) begin
         n_checks++;
         if (obs_words[i] !== 32'hA0 + 32'(i) || obs_last[i] != (i == 3))
            $display("FAIL basic_word%0d: got %h last %b want %h last %b",
                     i, obs_words[i], obs_last[i], 32'hA0 + 32'(i), i == 3);
         else n_pass++;
      end
      n_checks++;
      if (r_busy != 13 || r_lat != 2)
         $display("FAIL basic_timing: got busy %0d lat %0d want 13 2",
                  r_busy, r_lat);
      else n_pass++;
      n_checks++;
      if (xfer_count !== 32'(exp_cnt) || b_count !== 2'(exp_cnt))
         $display("FAIL basic_count: got %0d/%0d want %0d",
                  xfer_count, b_count, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      mem[0] = $urandom;
      mem[1] = $urandom;
      drive_run(2, 5, 0, -1, 1'b1);
      exp_cnt++;
      n_checks++;
      if (r_unstable != 0 || r_stall != 5)
         $display("FAIL bp_stall: got unstable %0d stalls %0d want 0 5",
                  r_unstable, r_stall);
      else n_pass++;
      n_checks++;
      if (obs_words.size() != 2 || obs_words[0] !== mem[0] ||
          obs_words[1] !== mem[1] || obs_last[0] || !obs_last[1])
         $display("FAIL bp_words: got %0d words want %h %h",
                  obs_words.size(), mem[0], mem[1]);
      else n_pass++;
      n_checks++;
      if (r_busy != 12 || r_mode_chg != 0)
         $display("FAIL bp_busy: got busy %0d modechg %0d want 12 0",
                  r_busy, r_mode_chg);
      else n_pass++;
      n_checks++;
      if (xfer_count !== 32'(exp_cnt))
         $display("FAIL bp_count: got %0d want %0d", xfer_count, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_illegal();
      int lens[2];
      lens[0] = 0;
      lens[1] = 1025;
      foreach (lens[k]) begin
         drive_run(lens[k], 0, 0, -1, 1'b0);
         exp_err = 1'b1;
         n_checks++;
         if (r_busy != 1 || r_vseen)
            $display("FAIL illegal%0d_busy: got busy %0d valid %b want 1 0",
                     lens[k], r_busy, r_vseen);
         else n_pass++;
         n_checks++;
         if (err_len !== exp_err || xfer_count !== 32'(exp_cnt))
            $display("FAIL illegal%0d_flags: got err %b cnt %0d want %b %0d",
                     lens[k], err_len, xfer_count, exp_err, exp_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_boundary();
      int lens[2];
      int nbad;
      lens[0] = 1;
      lens[1] = 1024;
      foreach (lens[k]) begin
         drive_run(lens[k], 0, 0, -1, 1'b0);
         exp_cnt++;
         nbad = 0;
         for (int i = 0; i < lens[k]; i++)
            if (i >= obs_words.size() || obs_words[i] !== mem[i] ||
                obs_last[i] != (i == lens[k] - 1)) nbad++;
         n_checks++;
         if (obs_words.size() != lens[k] || nbad != 0)
            $display("FAIL bound%0d_words: got %0d words %0d bad want %0d 0",
                     lens[k], obs_words.size(), nbad, lens[k]);
         else n_pass++;
         n_checks++;
         if (r_busy != 3 * lens[k] + 1 || xfer_count !== 32'(exp_cnt))
            $display("FAIL bound%0d_busy: got %0d cnt %0d want %0d %0d",
                     lens[k], r_busy, xfer_count, 3 * lens[k] + 1, exp_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_ghost_run();
      int ats[2];
      bit seen;
      ats[0] = 4;
      ats[1] = 9;
      foreach (ats[k]) begin
         drive_run(3, 0, 0, ats[k], 1'b0);
         exp_cnt++;
         seen = 0;
         repeat (3) begin
            if (dpram_busy !== 1'b0) seen = 1;
            @(negedge clk);
         end
         n_checks++;
         if (obs_words.size() != 3 || r_busy != 10 || seen)
            $display("FAIL ghost%0d: got %0d words busy %0d rebusy %b want 3 10 0",
                     ats[k], obs_words.size(), r_busy, seen);
         else n_pass++;
      end
      n_checks++;
      if (xfer_count !== 32'(exp_cnt))
         $display("FAIL ghost_count: got %0d want %0d", xfer_count, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_abort();
      int acc;
      int cyc;
      @(negedge clk);
      dpram_run = 1'b1;
      dpram_len = 16'd8;
      out_ready = 1'b1;
      @(negedge clk);
      dpram_run = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 2 && cyc < 100) begin
         if (out_valid === 1'b1) acc++;
         @(negedge clk);
         cyc++;
      end
      en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (acc != 2 || dpram_busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL abort_idle: got acc %0d busy %b valid %b want 2 0 0",
                  acc, dpram_busy, out_valid);
      else n_pass++;
      n_checks++;
      if (xfer_count !== 32'(exp_cnt) || err_len !== exp_err)
         $display("FAIL abort_kept: got %0d %b want %0d %b",
                  xfer_count, err_len, exp_cnt, exp_err);
      else n_pass++;
      @(negedge clk);
      en = 1'b1;
      mem[0] = $urandom;
      drive_run(1, 0, 0, -1, 1'b0);
      exp_cnt++;
      n_checks++;
      if (obs_words.size() != 1 || obs_words[0] !== mem[0] ||
          xfer_count !== 32'(exp_cnt))
         $display("FAIL abort_rerun: got %0d words cnt %0d want 1 %0d",
                  obs_words.size(), xfer_count, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int cyc;
      bit seen;
      @(negedge clk);
      cfg_mode = 1'b1;
      dpram_run = 1'b1;
      dpram_len = 16'd6;
      out_ready = 1'b0;
      @(negedge clk);
      dpram_run = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      #2 rst = 1'b1;
      #1;
      exp_cnt = 0;
      exp_err = 1'b0;
      n_checks++;
      if (cyc >= 50 || dpram_busy !== 1'b0 || dpram_mode !== 1'b0 ||
          out_valid !== 1'b0 || out_last !== 1'b0)
         $display("FAIL areset_ctl: got busy %b mode %b valid %b last %b want 0",
                  dpram_busy, dpram_mode, out_valid, out_last);
      else n_pass++;
      n_checks++;
      if (out_data !== 32'h0 || dpram_rd_addr !== '0 ||
          xfer_count !== 32'h0 || err_len !== 1'b0)
         $display("FAIL areset_data: got %h %h %0d %b want 0",
                  out_data, dpram_rd_addr, xfer_count, err_len);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      cfg_mode = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (dpram_busy !== 1'b0 || out_valid !== 1'b0) seen = 1;
      end
      n_checks++;
      if (seen)
         $display("FAIL areset_idle: got activity after release want none");
      else n_pass++;
   endtask

   task automatic test_mode_wrap();
      int len;
      int nbad;
      bit m;
      for (int t = 0; t < 5; t++) begin
         len = $urandom_range(1, 20);
         m = 1'($urandom);
         drive_run(len, 0, 30, int'($urandom_range(0, 40)), m);
         exp_cnt++;
         nbad = 0;
         for (int i = 0; i < len; i++)
            if (i >= obs_words.size() || obs_words[i] !== mem[i] ||
                obs_last[i] != (i == len - 1)) nbad++;
         n_checks++;
         if (obs_words.size() != len || nbad != 0 || r_unstable != 0)
            $display("FAIL rnd%0d_words: got %0d words %0d bad %0d unst want %0d 0 0",
                     t, obs_words.size(), nbad, r_unstable, len);
         else n_pass++;
         n_checks++;
         if (r_busy != 3 * len + 1 + r_stall || r_mode_chg != 0)
            $display("FAIL rnd%0d_busy: got %0d modechg %0d want %0d 0",
                     t, r_busy, r_mode_chg, 3 * len + 1 + r_stall);
         else n_pass++;
      end
      n_checks++;
      if (xfer_count !== 32'(exp_cnt) || b_count !== 2'(exp_cnt))
         $display("FAIL wrap_count: got %0d/%0d want %0d/%0d",
                  xfer_count, b_count, exp_cnt, exp_cnt % 4);
      else n_pass++;
      m = ~dpram_mode;
      cfg_mode = m;
      @(negedge clk);
      n_checks++;
      if (dpram_mode !== m)
         $display("FAIL mode_follow: got %b want %b", dpram_mode, m);
      else n_pass++;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal();
      test_boundary();
      test_ghost_run();
      test_abort();
      test_async_reset();
      test_mode_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
